// File: rtl/fifo_flops_reg.sv
// fifo_flops_reg: single-clock show-ahead FIFO held in a flip-flop register array.
// Dout always presents the oldest stored word. Pushes while full (without a pop) and
// pops while empty are dropped without disturbing the stored state.
// Optional build macro FIFO_FLOPS_ERR_FLAGS_EN adds sticky ovf/udf error flags.
module fifo_flops_reg #(
  parameter int depth = 16,
  parameter int bits  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] Din,
  input  logic            push,
  input  logic            pop,
  output logic [bits-1:0] Dout,
  output logic            full,
  output logic            pndng
`ifdef FIFO_FLOPS_ERR_FLAGS_EN
  ,
  output logic            ovf,
  output logic            udf
`endif
);

  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);

  localparam logic [PW-1:0] LAST_PTR = PW'(depth - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(depth);

  logic [bits-1:0] mem [depth];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic push_ok;
  logic pop_ok;

  // Flags come straight from the occupancy register.
  assign full  = (count == DEPTH_CNT);
  assign pndng = (count != '0);

  // A pop frees a slot in the same cycle, so push is still taken when full with pop.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && pndng;

  // Show-ahead head word; forced to zero while the queue is empty.
  assign Dout = pndng ? mem[rd_ptr] : '0;

  // Storage array: cleared on reset, written at the write pointer on accepted push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= Din;
    end
  end

  // Write pointer advances on accepted push, wrapping by explicit compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (push_ok) begin
      wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
    end
  end

  // Read pointer advances on accepted pop, wrapping by explicit compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
    end else if (pop_ok) begin
      rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
    end
  end

  // Occupancy: up on push only, down on pop only, unchanged when both or neither.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (push_ok && !pop_ok) begin
      count <= count + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count <= count - CW'(1);
    end
  end

`ifdef FIFO_FLOPS_ERR_FLAGS_EN
  // Sticky error flags: ovf on a dropped push, udf on an ignored pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (push && full && !pop) ovf <= 1'b1;
      if (pop && !pndng)        udf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_flops_reg.sv
// tb_fifo_flops_reg: directed scenarios plus randomized traffic for fifo_flops_reg,
// compared every cycle against a queue-based reference model.
// Build with FIFO_FLOPS_ERR_FLAGS_EN defined to also cover the ovf/udf flags.
module tb_fifo_flops_reg;

  localparam int DEPTH = 16;
  localparam int BITS  = 16;

  logic            clk;
  logic            rst;
  logic [BITS-1:0] Din;
  logic            push;
  logic            pop;
  logic [BITS-1:0] Dout;
  logic            full;
  logic            pndng;
`ifdef FIFO_FLOPS_ERR_FLAGS_EN
  logic            ovf;
  logic            udf;
`endif

  fifo_flops_reg #(DEPTH, BITS) dut (
    .clk   (clk),
    .rst   (rst),
    .Din   (Din),
    .push  (push),
    .pop   (pop),
    .Dout  (Dout),
    .full  (full),
    .pndng (pndng)
`ifdef FIFO_FLOPS_ERR_FLAGS_EN
    ,
    .ovf   (ovf),
    .udf   (udf)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: plain queue of stored words plus sticky error bits
  logic [BITS-1:0] q[$];
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // model update on each edge, using the inputs the DUT sees
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      automatic bit was_full  = (q.size() == DEPTH);
      automatic bit was_empty = (q.size() == 0);
      automatic bit do_pop    = pop && !was_empty;
      automatic bit do_push   = push && (!was_full || pop);
      if (push && was_full && !pop) m_ovf = 1'b1;
      if (pop && was_empty)         m_udf = 1'b1;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(Din);
    end
  end

  // per-cycle compare away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("dout",  int'(Dout),  (q.size() != 0) ? int'(q[0]) : 0);
      chk("count", int'(dut.count), q.size());
      chk("full",  int'(full),  int'(q.size() == DEPTH));
      chk("pndng", int'(pndng), int'(q.size() != 0));
`ifdef FIFO_FLOPS_ERR_FLAGS_EN
      chk("ovf",   int'(ovf),   int'(m_ovf));
      chk("udf",   int'(udf),   int'(m_udf));
`endif
    end
  end

  // set inputs for the next rising edge and log the transaction
  task automatic step(input logic ps, input logic pp, input logic [BITS-1:0] d);
    @(posedge clk);
    #2;
    push = ps;
    pop  = pp;
    Din  = d;
    $display("txn t=%0t push=%0d pop=%0d din=0x%0h model_count=%0d", $time, ps, pp, d, q.size());
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    push = 1'b0;
    pop  = 1'b0;
    Din  = '0;
    rst  = 1'b1;
    @(posedge clk);
    #2;
    rst  = 1'b0;
  endtask

  // watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    push = 1'b0;
    pop  = 1'b0;
    Din  = '0;
    @(posedge clk);
    #1;
    chk("rst_count", int'(dut.count), 0);
    chk("rst_full",  int'(full), 0);
    chk("rst_pndng", int'(pndng), 0);
    chk("rst_dout",  int'(Dout), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // fill and drain on alternate cycles
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, BITS'(i));
      step(1'b0, 1'b0, '0);
    end
    #1;
    chk("fill_full",  int'(full), 1);
    chk("fill_count", int'(dut.count), 16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, '0);
      #1;
      chk("drain_dout", int'(Dout), i);
      step(1'b0, 1'b0, '0);
    end
    #1;
    chk("drain_pndng", int'(pndng), 0);
    chk("drain_count", int'(dut.count), 0);

    // overflow: 40 pushes, only the first 16 survive
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, BITS'(i));
    step(1'b0, 1'b0, '0);
    #1;
    chk("ovf_count", int'(dut.count), 16);
    chk("ovf_full",  int'(full), 1);
`ifdef FIFO_FLOPS_ERR_FLAGS_EN
    chk("ovf_flag", int'(ovf), 1);
`endif
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, '0);
      #1;
      chk("ovf_drain_dout", int'(Dout), i);
    end
    step(1'b0, 1'b0, '0);
    #1;
    chk("ovf_end_count", int'(dut.count), 0);

    // underflow: 20 pops on empty, then one push
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    #1;
    chk("udf_count", int'(dut.count), 0);
    chk("udf_pndng", int'(pndng), 0);
    chk("udf_dout",  int'(Dout), 0);
`ifdef FIFO_FLOPS_ERR_FLAGS_EN
    chk("udf_flag", int'(udf), 1);
`endif
    step(1'b1, 1'b0, 16'h00A5);
    step(1'b0, 1'b0, '0);
    #1;
    chk("udf_push_dout",  int'(Dout), 16'hA5);
    chk("udf_push_count", int'(dut.count), 1);

    // simultaneous push+pop with 5 words preloaded
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, BITS'(100 + i));
    for (int j = 0; j < 17; j++) begin
      step(1'b1, 1'b1, BITS'(200 + j));
      #1;
      chk("pp_dout", int'(Dout), (j < 5) ? 100 + j : 200 + j - 5);
    end
    step(1'b0, 1'b0, '0);
    #1;
    chk("pp_count", int'(dut.count), 5);
    do_reset();
    step(1'b1, 1'b1, 16'h0007);
    step(1'b0, 1'b0, '0);
    #1;
    chk("pp_empty_count", int'(dut.count), 1);
    chk("pp_empty_dout",  int'(Dout), 7);

    // interleaved push/pop, crossing the pointer wrap
    do_reset();
    for (int d = 0; d <= 16; d++) begin
      step(1'b1, 1'b0, BITS'(d));
      step(1'b0, 1'b1, '0);
      #1;
      chk("il_dout",  int'(Dout), d);
      chk("il_count", int'(dut.count), 1);
    end
    step(1'b0, 1'b0, '0);
    #1;
    chk("il_end_count", int'(dut.count), 0);

    // asynchronous reset between edges with 7 words stored
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, BITS'(50 + i));
    step(1'b0, 1'b0, '0);
    #1;
    chk("ar_pre_count", int'(dut.count), 7);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_count", int'(dut.count), 0);
    chk("ar_full",  int'(full), 0);
    chk("ar_pndng", int'(pndng), 0);
    chk("ar_dout",  int'(Dout), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // randomized traffic with varying push/pop bias
    for (int ph = 0; ph < 3; ph++) begin
      automatic int push_pct = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
      for (int n = 0; n < 250; n++) begin
        automatic logic ps = ($urandom_range(99) < push_pct);
        automatic logic pp = ($urandom_range(99) < (100 - push_pct));
        step(ps, pp, BITS'($urandom));
      end
    end
    step(1'b0, 1'b0, '0);
    @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
